// File: rtl/ldm_stm_addr_seq_if.sv
// Bus bundle for the LDM/STM address sequencer: control-side request, memory beat
// handshake and completion/writeback outputs.
interface ldm_stm_addr_seq_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned NREG   = 16
);
    localparam int unsigned IDX_W = $clog2(NREG);

    logic              start_in;
    logic [ADDR_W-1:0] base_addr_in;
    logic [NREG-1:0]   reg_list_in;
    logic [2:0]        mode_in;
    logic              mem_ack_in;
    logic              busy_out;
    logic              mem_req_out;
    logic [ADDR_W-1:0] addr_to_mem_out;
    logic [IDX_W-1:0]  reg_idx_out;
    logic              last_out;
    logic              done_out;
    logic              wb_valid_out;
    logic [ADDR_W-1:0] data_to_reg_update_out;
    logic              align_err_out;

    modport master (
        output start_in, base_addr_in, reg_list_in, mode_in, mem_ack_in,
        input  busy_out, mem_req_out, addr_to_mem_out, reg_idx_out, last_out,
               done_out, wb_valid_out, data_to_reg_update_out, align_err_out
    );

    modport slave (
        input  start_in, base_addr_in, reg_list_in, mode_in, mem_ack_in,
        output busy_out, mem_req_out, addr_to_mem_out, reg_idx_out, last_out,
               done_out, wb_valid_out, data_to_reg_update_out, align_err_out
    );
endinterface

// File: rtl/ldm_stm_addr_seq.sv
// LDM/STM block-transfer address sequencer: one ascending word address per acked beat.
// Optional base-alignment check enabled by defining ADDR_ALIGN_CHECK_EN.
module ldm_stm_addr_seq #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned NREG       = 16,
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    ldm_stm_addr_seq_if.slave   bus
);
    localparam int unsigned IDX_W = $clog2(NREG);
    localparam int unsigned CNT_W = $clog2(NREG + 1);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d, wbval_q, wbval_d, data_q, data_d;
    logic [NREG-1:0]   rem_q, rem_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              w_q, w_d;
    logic              busy_q, busy_d, req_q, req_d, last_q, last_d;
    logic              done_q, done_d, wbv_q, wbv_d;
`ifdef ADDR_ALIGN_CHECK_EN
    logic              aerr_q, aerr_d;
    logic              misaligned;
    assign misaligned = (bus.base_addr_in & ADDR_W'(WORD_BYTES - 1)) != '0;
`endif

    // One lowest-set-bit picker serves both the fresh list at start and the remaining list per beat
    logic [NREG-1:0]  pick_src, pick_rest;
    logic [IDX_W-1:0] pick_idx;
    always_comb begin
        pick_src = (state_q == IDLE) ? bus.reg_list_in : rem_q;
        pick_idx = '0;
        for (int unsigned i = NREG; i > 0; i--) begin
            if (pick_src[i-1]) pick_idx = IDX_W'(i - 1);
        end
        pick_rest = pick_src & (pick_src - NREG'(1));
    end

    logic [CNT_W-1:0]  n_set;
    logic [ADDR_W-1:0] span, first_addr, wb_calc;
    always_comb begin
        n_set = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            n_set = n_set + CNT_W'(bus.reg_list_in[i]);
        end
        span = STRIDE * ADDR_W'(n_set);
        case (bus.mode_in[2:1])
            2'b01:   first_addr = bus.base_addr_in;
            2'b11:   first_addr = bus.base_addr_in + STRIDE;
            2'b00:   first_addr = bus.base_addr_in - span + STRIDE;
            default: first_addr = bus.base_addr_in - span;
        endcase
        wb_calc = bus.mode_in[1] ? (bus.base_addr_in + span) : (bus.base_addr_in - span);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wbval_q <= '0;
            data_q  <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            w_q     <= 1'b0;
            busy_q  <= 1'b0;
            req_q   <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            wbv_q   <= 1'b0;
`ifdef ADDR_ALIGN_CHECK_EN
            aerr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wbval_q <= wbval_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            w_q     <= w_d;
            busy_q  <= busy_d;
            req_q   <= req_d;
            last_q  <= last_d;
            done_q  <= done_d;
            wbv_q   <= wbv_d;
`ifdef ADDR_ALIGN_CHECK_EN
            aerr_q  <= aerr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start_in) begin
                    state_d = (n_set == '0) ? DONE : XFER;
`ifdef ADDR_ALIGN_CHECK_EN
                    if (misaligned) state_d = DONE;
`endif
                end
            end
            XFER:    if (bus.mem_ack_in && last_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        wbval_d = wbval_q;
        data_d  = data_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        w_d     = w_q;
        last_d  = last_q;
        req_d   = (state_d == XFER);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        wbv_d   = 1'b0;
`ifdef ADDR_ALIGN_CHECK_EN
        aerr_d  = aerr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start_in) begin
                    w_d     = bus.mode_in[0];
                    wbval_d = wb_calc;
                    addr_d  = first_addr;
                    idx_d   = pick_idx;
                    rem_d   = pick_rest;
                    last_d  = req_d && (pick_rest == '0);
                    if ((state_d == DONE) && bus.mode_in[0]) begin
                        wbv_d  = 1'b1;
                        data_d = wb_calc;
                    end
`ifdef ADDR_ALIGN_CHECK_EN
                    aerr_d = misaligned;
                    if (misaligned) wbv_d = 1'b0;
`endif
                end
            end
            XFER: begin
                if (bus.mem_ack_in) begin
                    if (last_q) begin
                        last_d = 1'b0;
                        wbv_d  = w_q;
                        data_d = wbval_q;
                    end else begin
                        addr_d = addr_q + STRIDE;
                        idx_d  = pick_idx;
                        rem_d  = pick_rest;
                        last_d = (pick_rest == '0);
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.busy_out               = busy_q;
    assign bus.mem_req_out            = req_q;
    assign bus.addr_to_mem_out        = addr_q;
    assign bus.reg_idx_out            = idx_q;
    assign bus.last_out               = last_q;
    assign bus.done_out               = done_q;
    assign bus.wb_valid_out           = wbv_q;
    assign bus.data_to_reg_update_out = data_q;
`ifdef ADDR_ALIGN_CHECK_EN
    assign bus.align_err_out          = aerr_q;
`else
    assign bus.align_err_out          = 1'b0;
`endif
endmodule

// File: tb/tb_ldm_stm_addr_seq.sv
// Directed scoreboard bench for ldm_stm_addr_seq (default build, alignment check off).
module tb_ldm_stm_addr_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ldm_stm_addr_seq_if #(.ADDR_W(32), .NREG(16)) bif ();

    ldm_stm_addr_seq #(.ADDR_W(32), .NREG(16), .WORD_BYTES(4)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bif)
    );

    typedef struct { logic [31:0] addr; logic [3:0] idx; logic last; } beat_t;
    typedef struct { logic wbv; logic [31:0] data; } done_t;
    beat_t beat_q[$];
    done_t done_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [3:0] i, input logic l);
        beat_t b;
        b.addr = a; b.idx = i; b.last = l;
        beat_q.push_back(b);
    endtask

    task automatic push_done(input logic w, input logic [31:0] d);
        done_t e;
        e.wbv = w; e.data = d;
        done_q.push_back(e);
    endtask

    // Scoreboard: every accepted beat and every done pulse is matched against queued expectations
    always @(negedge clk) begin
        if (rst_n) begin
            if (bif.mem_req_out && bif.mem_ack_in) begin
                chk("beat_expected", 32'(beat_q.size() != 0), 32'd1);
                if (beat_q.size() != 0) begin
                    beat_t b;
                    b = beat_q.pop_front();
                    chk("beat_addr", bif.addr_to_mem_out, b.addr);
                    chk("beat_idx", 32'(bif.reg_idx_out), 32'(b.idx));
                    chk("beat_last", 32'(bif.last_out), 32'(b.last));
                end
            end
            if (bif.done_out) begin
                chk("done_expected", 32'(done_q.size() != 0), 32'd1);
                if (done_q.size() != 0) begin
                    done_t e;
                    e = done_q.pop_front();
                    chk("wb_valid", 32'(bif.wb_valid_out), 32'(e.wbv));
                    if (e.wbv) chk("wb_data", bif.data_to_reg_update_out, e.data);
                end
            end
            if (bif.wb_valid_out && !bif.done_out) chk("wb_without_done", 32'd1, 32'd0);
        end
    end

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic start_blk(input logic [31:0] base, input logic [15:0] list,
                             input logic [2:0] mode, input bit hold);
        bif.start_in     = 1'b1;
        bif.base_addr_in = base;
        bif.reg_list_in  = list;
        bif.mode_in      = mode;
        next_edge();
        if (!hold) bif.start_in = 1'b0;
    endtask

    task automatic wait_done(input int cyc0, input int exp, input string tag);
        int cyc;
        cyc = cyc0;
        repeat (20) begin
            @(negedge clk);
            cyc++;
            if (bif.done_out) break;
        end
        chk(tag, 32'(cyc), 32'(exp));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(bif.busy_out), 32'd0);
        chk({tag, "_req"}, 32'(bif.mem_req_out), 32'd0);
        chk({tag, "_last"}, 32'(bif.last_out), 32'd0);
        chk({tag, "_done"}, 32'(bif.done_out), 32'd0);
        chk({tag, "_wbv"}, 32'(bif.wb_valid_out), 32'd0);
        chk({tag, "_aerr"}, 32'(bif.align_err_out), 32'd0);
        chk({tag, "_addr"}, bif.addr_to_mem_out, 32'd0);
        chk({tag, "_idx"}, 32'(bif.reg_idx_out), 32'd0);
        chk({tag, "_data"}, bif.data_to_reg_update_out, 32'd0);
    endtask

    initial begin
        rst_n            = 1'b0;
        bif.start_in     = 1'b0;
        bif.base_addr_in = '0;
        bif.reg_list_in  = '0;
        bif.mode_in      = '0;
        bif.mem_ack_in   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        next_edge();
        rst_n = 1'b1;
        next_edge();

        // IA, ack held high: first beat in cycle 1, done + wb in cycle 5
        bif.mem_ack_in = 1'b1;
        push_beat(32'h1000, 4'd0, 1'b0);
        push_beat(32'h1004, 4'd1, 1'b0);
        push_beat(32'h1008, 4'd2, 1'b0);
        push_beat(32'h100C, 4'd3, 1'b1);
        push_done(1'b1, 32'h1010);
        start_blk(32'h1000, 16'h000F, 3'b011, 1'b0);
        @(negedge clk);
        chk("ia_first_req", 32'(bif.mem_req_out), 32'd1);
        chk("ia_busy", 32'(bif.busy_out), 32'd1);
        wait_done(1, 5, "ia_done_cycle");
        next_edge();
        @(negedge clk);
        chk("ia_idle_busy", 32'(bif.busy_out), 32'd0);
        next_edge();

        // DB with start held high throughout: it must be ignored outside IDLE
        push_beat(32'h1FF8, 4'd0, 1'b0);
        push_beat(32'h1FFC, 4'd15, 1'b1);
        push_done(1'b1, 32'h1FF8);
        start_blk(32'h2000, 16'h8001, 3'b101, 1'b1);
        wait_done(0, 3, "db_done_cycle");
        bif.start_in = 1'b0;
        next_edge();

        // DA: first address base - 8 + 4, writeback base - 8
        push_beat(32'h0FFC, 4'd0, 1'b0);
        push_beat(32'h1000, 4'd2, 1'b1);
        push_done(1'b1, 32'h0FF8);
        start_blk(32'h1000, 16'h0005, 3'b001, 1'b0);
        wait_done(0, 3, "da_done_cycle");
        next_edge();

        // IB with ack withheld for 3 cycles: beat must stay stable
        bif.mem_ack_in = 1'b0;
        push_beat(32'h104, 4'd2, 1'b1);
        push_done(1'b0, 32'h0);
        start_blk(32'h100, 16'h0004, 3'b110, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("ib_hold_req", 32'(bif.mem_req_out), 32'd1);
            chk("ib_hold_addr", bif.addr_to_mem_out, 32'h104);
            chk("ib_hold_idx", 32'(bif.reg_idx_out), 32'd2);
            chk("ib_hold_last", 32'(bif.last_out), 32'd1);
        end
        next_edge();
        bif.mem_ack_in = 1'b1;
        wait_done(3, 5, "ib_done_cycle");
        next_edge();

        // Empty list: done and wb=base in cycle 1, no beat
        push_done(1'b1, 32'h40);
        start_blk(32'h40, 16'h0000, 3'b011, 1'b0);
        wait_done(0, 1, "empty_done_cycle");
        chk("empty_no_req", 32'(bif.mem_req_out), 32'd0);
        next_edge();

        // Wrap-around, started in the cycle right after DONE
        push_beat(32'hFFFF_FFFC, 4'd0, 1'b0);
        push_beat(32'h0000_0000, 4'd1, 1'b1);
        push_done(1'b1, 32'h4);
        start_blk(32'hFFFF_FFFC, 16'h0003, 3'b011, 1'b0);
        wait_done(0, 3, "wrap_done_cycle");
        next_edge();

        // Reset after 2 of 4 beats: outputs clear at once, no done
        push_beat(32'h3000, 4'd0, 1'b0);
        push_beat(32'h3004, 4'd1, 1'b0);
        start_blk(32'h3000, 16'h000F, 3'b011, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        repeat (3) begin
            @(negedge clk);
            chk("midreset_no_done", 32'(bif.done_out), 32'd0);
        end
        next_edge();
        rst_n = 1'b1;
        next_edge();
        chk("midreset_beats_consumed", 32'(beat_q.size()), 32'd0);

        push_beat(32'h500, 4'd1, 1'b1);
        push_done(1'b0, 32'h0);
        start_blk(32'h500, 16'h0002, 3'b010, 1'b0);
        wait_done(0, 2, "post_reset_done_cycle");
        next_edge();
        repeat (2) next_edge();
        chk("beats_left", 32'(beat_q.size()), 32'd0);
        chk("dones_left", 32'(done_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
